rr_arbiter_hold: RTL
====================

RR_ARBITER_HOLD -- requirements
Module: rr_arbiter_hold

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 20, number of requester ports (legal range 2..64).
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive grant cycles per tenure (legal 1..255).
REQ-003 SHALL derive localparam IDX_W = $clog2(NUM_PORTS) for the index output width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_i  input  NUM_PORTS  per-port request level, bit k = port k.
REQ-007 SHALL have port gnt_o  output  NUM_PORTS  registered grant, one-hot or all-zero.
REQ-008 SHALL have port gnt_valid_o  output  1  registered, equal to |gnt_o.
REQ-009 SHALL have port gnt_idx_o  output  IDX_W  registered binary index of the granted port; 0 when no grant.

Function
REQ-010 SHALL sample req_i at each rising clk edge and present the resulting decision on gnt_o at that same edge (one-cycle request-to-grant latency).
REQ-011 SHALL never assert more than one gnt_o bit, and SHALL never grant a port whose req_i bit was 0 at the deciding edge.
REQ-012 SHALL keep a rotating pointer ptr (IDX_W bits); the search starts at port ptr and proceeds upward, wrapping NUM_PORTS-1 -> 0.
REQ-013 SHALL, on a new grant to port k, set ptr = k+1, wrapping to 0 when k = NUM_PORTS-1, and clear hold_cnt to 0.
REQ-014 SHALL implement FSM IDLE (no grant) and HOLD (one port granted); IDLE->HOLD on any request; HOLD->IDLE when no request is present.
REQ-015 SHALL, in HOLD with the holder's request still high and hold_cnt < MAX_HOLD-1, keep the same grant and increment hold_cnt.
REQ-016 SHALL, in HOLD when hold_cnt = MAX_HOLD-1, re-arbitrate from ptr; if another port requests, it wins; if the holder is the only requester, it is re-granted with hold_cnt = 0.
REQ-017 SHALL, when the holder drops its request, re-arbitrate at that same edge (no idle bubble if others request); ptr is unchanged by the release.
REQ-018 SHALL, with req_i = 0, drive gnt_o = 0, gnt_valid_o = 0 and gnt_idx_o = 0 and leave ptr unchanged.
REQ-019 SHALL, with MAX_HOLD = 1, degenerate to pure per-cycle round-robin.
REQ-020 SHALL keep gnt_idx_o consistent with gnt_o in every cycle.

Reset
REQ-021 SHALL, while rst = 0, immediately force gnt_o = 0, gnt_valid_o = 0, gnt_idx_o = 0, ptr = 0, hold_cnt = 0 and FSM = IDLE, independent of clk.
REQ-022 SHALL, on reset assertion mid-tenure, drop the grant without waiting for an edge; the first edge after release arbitrates from ptr = 0.

Configuration
REQ-023 SHALL, when macro RR_ARBITER_PRIO_EN is defined, add port prio_i  input  NUM_PORTS  per-port high-priority qualifier.
REQ-024 SHALL, with RR_ARBITER_PRIO_EN defined, arbitrate round-robin (same ptr) only among req_i & prio_i whenever that set is non-zero, else among req_i.
REQ-025 SHALL, with RR_ARBITER_PRIO_EN defined, preempt a non-priority holder at the next edge when any priority request appears, regardless of hold_cnt.
REQ-026 SHALL, without RR_ARBITER_PRIO_EN, omit prio_i and treat all requests equally.

Verification (NUM_PORTS=4, MAX_HOLD=3)
REQ-027 SHALL cover: rst=0 with req_i=1111 -> gnt_o=0000, gnt_valid_o=0, gnt_idx_o=0 throughout reset.
REQ-028 SHALL cover: req_i=1111 held after reset -> gnt_o 0001 x3, 0010 x3, 0100 x3, 1000 x3, then 0001 (wrap).
REQ-029 SHALL cover: req_i=0100 held 7 cycles -> gnt_o=0100, gnt_idx_o=2 every cycle, with re-tenure at cycles 4 and 7.
REQ-030 SHALL cover: req_i=0011, port 0 granted, req_i[0] dropped after 1 cycle -> gnt_o=0010 at the next edge.
REQ-031 SHALL cover: rst pulsed low between edges while gnt_o=0100 -> gnt_o=0000 before the next edge; after release with req_i=1111 -> gnt_o=0001.
REQ-032 SHALL cover (RR_ARBITER_PRIO_EN): port 0 holding with hold_cnt=0, prio_i=1000, req_i=1111 -> gnt_o=1000 at the next edge.

Source files
------------

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold
//   Round-robin arbiter with bounded grant tenure. A granted port keeps its
//   grant while it requests, for at most MAX_HOLD consecutive cycles. After
//   that the arbiter searches again from the rotating pointer. The pointer
//   only moves when a new grant is issued. It is left alone when a holder
//   releases or when nobody is requesting.
//
//   Optional build macro: RR_ARBITER_PRIO_EN adds prio_i. When any request
//   has its prio_i bit set, arbitration runs only among those requests. Such
//   a request also preempts a non-priority holder at the next edge.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   req_i        in   [NUM_PORTS] request level per port
//   prio_i       in   [NUM_PORTS] high-priority qualifier (RR_ARBITER_PRIO_EN only)
//   gnt_o        out  [NUM_PORTS] registered grant, one-hot or zero
//   gnt_valid_o  out  registered, equal to |gnt_o
//   gnt_idx_o    out  [IDX_W] registered index of the granted port, 0 when idle
//   dbg_state_o  out  FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: there is no back-pressure. A request is a level. A grant seen
// on gnt_o is the decision made from req_i sampled at that same clock edge.
// The requester keeps req_i high for as long as it wants to hold the grant.
module rr_arbiter_hold #(
  parameter  int NUM_PORTS = 20,
  parameter  int MAX_HOLD  = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
`ifdef RR_ARBITER_PRIO_EN
  input  logic [NUM_PORTS-1:0] prio_i,
`endif
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);

  state_t               r_state, w_state_n;
  logic [NUM_PORTS-1:0] r_gnt,   w_gnt_n;
  logic [IDX_W-1:0]     r_idx,   w_idx_n;
  logic [IDX_W-1:0]     r_ptr,   w_ptr_n;
  logic [7:0]           r_hold,  w_hold_n;

  logic [NUM_PORTS-1:0] w_cand;
  logic                 w_preempt;
  logic                 w_holder_req;
  logic [IDX_W-1:0]     w_win;

  // First set bit of cand at or above start, wrapping past the top port.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] cand,
                                               input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(start) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && cand[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    return pick;
  endfunction

  // Select the candidate set, and decide whether a priority request preempts the holder.
`ifdef RR_ARBITER_PRIO_EN
  logic [NUM_PORTS-1:0] w_prio_req;
  always_comb begin
    w_prio_req = req_i & prio_i;
    w_cand     = (|w_prio_req) ? w_prio_req : req_i;
    w_preempt  = (|w_prio_req) && !prio_i[r_idx];
  end
`else
  always_comb begin
    w_cand    = req_i;
    w_preempt = 1'b0;
  end
`endif

  always_comb begin
    w_holder_req = req_i[r_idx];
    w_win        = rr_pick(w_cand, r_ptr);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_idx_n   = r_idx;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;

    if (!(|req_i)) begin
      // Nobody is requesting: go idle and leave the pointer where it is.
      w_state_n = ST_IDLE;
      w_gnt_n   = '0;
      w_idx_n   = '0;
      w_hold_n  = '0;
    end else if (r_state == ST_HOLD && w_holder_req &&
                 r_hold < HOLD_LAST && !w_preempt) begin
      // The tenure continues. The grant is unchanged.
      w_hold_n = r_hold + 8'd1;
    end else begin
      // Fresh grant. This covers leaving idle, the holder releasing, tenure
      // expiry and preemption. At expiry the search starts just past the
      // holder, so any other requester wins first. The holder is picked again
      // only when it is the only requester.
      w_state_n        = ST_HOLD;
      w_gnt_n          = '0;
      w_gnt_n[w_win]   = 1'b1;
      w_idx_n          = w_win;
      w_ptr_n          = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
      w_hold_n         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_idx   <= w_idx_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = (r_state == ST_HOLD);
  assign gnt_idx_o   = r_idx;
  assign dbg_state_o = r_state;

endmodule
